// File: rtl/seq_arith.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_arith                                                    |
// | Description : Sequential unsigned arithmetic unit with a start/done        |
// |               handshake. Supports add, sub, unsigned min and an optional   |
// |               iterative shift-add multiply. Each op reports an             |
// |               overflow/borrow flag alongside the result.                   |
// | Ports       : clk    - rising-edge clock                                   |
// |               reset  - asynchronous active-low reset                       |
// |               start  - request, sampled only while idle                    |
// |               op     - 0=add 1=sub 2=mul 3=min                             |
// |               a, b   - operands, sampled one cycle after start            |
// |               result - registered result, held until the next completion  |
// |               done   - high when idle/complete, low while busy             |
// |               ovf    - carry/borrow/multiply-overflow flag                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_arith #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             ovf
);

    localparam int         c_CNT_W = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LATCH = 2'd1;
    localparam logic [1:0] c_EXEC  = 2'd2;
    localparam logic [1:0] c_MUL   = 2'd3;

    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_SUB = 2'd1;
    localparam logic [1:0] c_OP_MUL = 2'd2;
    localparam logic [1:0] c_OP_MIN = 2'd3;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;

    // Single-cycle datapath, one extra bit to catch carry/borrow
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_min;

    // Handshake from the multiplier (constant zero when it is omitted)
    logic             w_mul_last;
    logic [WIDTH-1:0] w_mul_lo;
    logic             w_mul_ovf;

    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_diff = {1'b0, r_a} - {1'b0, r_b};
        w_min  = (r_a < r_b) ? r_a : r_b;
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            logic [2*WIDTH-1:0] r_mul_a;
            logic [WIDTH-1:0]   r_mul_b;
            logic [2*WIDTH-1:0] r_acc;
            logic [c_CNT_W-1:0] r_cnt;
            logic [2*WIDTH-1:0] w_acc_next;

            localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

            always_comb begin
                w_acc_next = r_mul_b[0] ? (r_acc + r_mul_a) : r_acc;
            end

            // Operands are loaded straight from the ports in the LATCH cycle so
            // the shifting copies are ready on the first MUL cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_mul_a <= '0;
                    r_mul_b <= '0;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else if (r_state == c_LATCH && op == c_OP_MUL) begin
                    r_mul_a <= {{WIDTH{1'b0}}, a};
                    r_mul_b <= b;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else if (r_state == c_MUL) begin
                    r_acc   <= w_acc_next;
                    r_mul_a <= r_mul_a << 1;
                    r_mul_b <= r_mul_b >> 1;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                end
            end

            // Completion uses the accumulator value being formed this cycle
            assign w_mul_last = (r_state == c_MUL) && (r_cnt == c_CNT_LAST);
            assign w_mul_lo   = w_acc_next[WIDTH-1:0];
            assign w_mul_ovf  = |w_acc_next[2*WIDTH-1:WIDTH];
        end else begin : g_no_mul
            assign w_mul_last = 1'b0;
            assign w_mul_lo   = '0;
            assign w_mul_ovf  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            result  <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        done    <= 1'b0;
                        r_state <= c_LATCH;
                    end else begin
                        done    <= 1'b1;
                    end
                end
                c_LATCH: begin
                    r_a  <= a;
                    r_b  <= b;
                    r_op <= op;
                    if (op == c_OP_MUL && MUL_EN != 0) begin
                        r_state <= c_MUL;
                    end else begin
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    case (r_op)
                        c_OP_ADD: begin
                            result <= w_sum[WIDTH-1:0];
                            ovf    <= w_sum[WIDTH];
                        end
                        c_OP_SUB: begin
                            result <= w_diff[WIDTH-1:0];
                            ovf    <= w_diff[WIDTH];
                        end
                        c_OP_MIN: begin
                            result <= w_min;
                            ovf    <= 1'b0;
                        end
                        default: begin
                            // Multiply requested on an instance without one
                            result <= '0;
                            ovf    <= 1'b1;
                        end
                    endcase
                    done    <= 1'b1;
                    r_state <= c_IDLE;
                end
                c_MUL: begin
                    if (w_mul_last) begin
                        result  <= w_mul_lo;
                        ovf     <= w_mul_ovf;
                        done    <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_arith.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_arith                                                 |
// | Description : Directed self-checking bench for seq_arith. One instance     |
// |               with the multiplier, one without.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_arith;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start0;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    logic [31:0] result1;
    logic        done1;
    logic        ovf1;
    logic [31:0] result0;
    logic        done0;
    logic        ovf0;

    logic        sel;
    logic [31:0] s_result;
    logic        s_done;
    logic        s_ovf;

    int n_vec;
    int n_err;

    seq_arith #(.WIDTH(32), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result1), .done(done1), .ovf(ovf1)
    );

    seq_arith #(.WIDTH(32), .MUL_EN(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .op(op), .a(a), .b(b),
        .result(result0), .done(done0), .ovf(ovf0)
    );

    always_comb begin
        s_result = sel ? result0 : result1;
        s_done   = sel ? done0   : done1;
        s_ovf    = sel ? ovf0    : ovf1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Start pulse sampled at edge k, valid operands for the LATCH edge k+1,
    // then garbage operands afterwards to show they no longer matter.
    task automatic start_op(input logic use0, input logic [1:0] o,
                            input logic [31:0] xa, input logic [31:0] xb);
        sel = use0;
        @(negedge clk);
        if (use0) start0 = 1'b1; else start = 1'b1;
        op = 2'bxx;
        a  = 32'hDEAD_BEEF;
        b  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        chk("busy_after_start", {31'd0, s_done}, 32'd0);
        @(negedge clk);
        start  = 1'b0;
        start0 = 1'b0;
        op = o;
        a  = xa;
        b  = xb;
        @(posedge clk);
        @(negedge clk);
        a  = 32'd1;
        b  = 32'hFFFF_FFFF;
        op = 2'd0;
    endtask

    // Counts edges after LATCH until done; optionally pokes start while busy.
    task automatic wait_done(input string tag, input int exp_n, input bit poke);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!s_done && poke) begin
                @(negedge clk);
                start = (n >= 3 && n <= 5);
            end
        end while (!s_done && n < 100);
        start = 1'b0;
        chk(tag, n, exp_n);
    endtask

    task automatic expect_res(input string tag, input logic [31:0] r, input logic f);
        chk({tag, "_result"}, s_result, r);
        chk({tag, "_ovf"}, {31'd0, s_ovf}, {31'd0, f});
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b0;
        start  = 1'b0;
        start0 = 1'b0;
        op     = 2'd0;
        a      = '0;
        b      = '0;
        sel    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result1, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_ovf", {31'd0, ovf1}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_done_low", {31'd0, done1}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_done_high", {31'd0, done1}, 32'd1);

        // add 5+7, then idle stability
        start_op(1'b0, 2'd0, 32'd5, 32'd7);
        wait_done("add_lat", 1, 1'b0);
        expect_res("add5_7", 32'd12, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("add_hold_result", s_result, 32'd12);
        chk("add_hold_done", {31'd0, s_done}, 32'd1);

        // add with carry, then back-to-back sub with borrow
        start_op(1'b0, 2'd0, 32'hFFFF_FFFF, 32'd1);
        wait_done("addc_lat", 1, 1'b0);
        expect_res("add_carry", 32'd0, 1'b1);
        start_op(1'b0, 2'd1, 32'd3, 32'd5);
        wait_done("sub_lat", 1, 1'b0);
        expect_res("sub3_5", 32'hFFFF_FFFE, 1'b1);

        // multiply with start pokes while busy; only one completion
        start_op(1'b0, 2'd2, 32'd1234, 32'd5678);
        wait_done("mul_lat", 32, 1'b1);
        expect_res("mul1234_5678", 32'h006A_E9BC, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("mul_single_done", {31'd0, s_done}, 32'd1);
        chk("mul_single_result", s_result, 32'h006A_E9BC);

        start_op(1'b0, 2'd2, 32'h0001_0000, 32'h0001_0000);
        wait_done("mulovf_lat", 32, 1'b0);
        expect_res("mul_ovf", 32'd0, 1'b1);

        // min with operands scrambled after LATCH
        start_op(1'b0, 2'd3, 32'd9, 32'd4);
        wait_done("min_lat", 1, 1'b0);
        expect_res("min9_4", 32'd4, 1'b0);

        // async reset in the middle of a multiply
        start_op(1'b0, 2'd1, 32'd3, 32'd5);
        wait_done("sub2_lat", 1, 1'b0);
        start_op(1'b0, 2'd2, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_result", result1, 32'd0);
        chk("midrst_done", {31'd0, done1}, 32'd0);
        chk("midrst_ovf", {31'd0, ovf1}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_done_low", {31'd0, done1}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_done_high", {31'd0, done1}, 32'd1);
        start_op(1'b0, 2'd0, 32'd2, 32'd2);
        wait_done("add2_lat", 1, 1'b0);
        expect_res("add2_2", 32'd4, 1'b0);

        // instance without multiplier: op 2 is illegal
        start_op(1'b1, 2'd2, 32'd3, 32'd4);
        wait_done("nomul_lat", 1, 1'b0);
        expect_res("nomul", 32'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
